// File: rtl/mjpeg_ddr3_wr_packer.sv
// Packs MJPEG bytes into DATA_W-bit words, queues {data,mask,addr} and writes them to DDR3 in bursts over rotating frame slots.
// A word reaches the DDR3 strobes 2+ cycles after its push; a low controller ready stalls writes, and a full FIFO drops words (sticky o_overflow).
module mjpeg_ddr3_wr_packer #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int SLOT_COUNT = 4,
    parameter int ADDR_W     = 28,
    parameter int ADDR_STEP  = 8,
    parameter int SLOT_SHIFT = 22,
    parameter int LEN_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_frame_start,
    input  logic                  i_frame_end,
    input  logic                  i_byte_de,
    input  logic [7:0]            i_byte_data,
    input  logic                  i_rd_busy,
    input  logic [2:0]            i_rd_slot,
    output logic [2:0]            o_ddr3_cmd,
    output logic                  o_ddr3_cmd_en,
    output logic [ADDR_W-1:0]     o_ddr3_addr,
    input  logic                  i_ddr3_cmd_ready,
    input  logic                  i_ddr3_wr_data_rdy,
    output logic [DATA_W-1:0]     o_ddr3_wr_data,
    output logic                  o_ddr3_wr_data_en,
    output logic                  o_ddr3_wr_data_end,
    output logic [DATA_W/8-1:0]   o_ddr3_wr_mask,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic [2:0]            o_frame_slot,
    output logic [LEN_W-1:0]      o_frame_bytes,
    output logic                  o_overflow
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [31:0] SLOT_CAP = 32'((1 << SLOT_SHIFT) / ADDR_STEP);

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_GAP} wstate_t;
    wstate_t state, state_nxt;

    logic [2:0]        wr_slot, slot_cand, slot_nxt;
    logic              flush;
    logic [DATA_W-1:0] sr, sr_nxt, push_data;
    logic [CW-1:0]     lane_cnt, lane_nxt;
    logic [LEN_W-1:0]  byte_cnt, word_idx;
    logic [NB-1:0]     push_mask;
    logic [ADDR_W-1:0] push_addr;
    logic              open_frame, take_byte, end_frame, close_frame;
    logic              push, push_ok, pop;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [NB-1:0]     mem_mask [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic [BW-1:0]     burst_cnt;
    logic              fifo_empty, fifo_full;

    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == (AW+1)'(FIFO_DEPTH));
    assign open_frame  = i_frame_start && !o_busy;
    assign take_byte   = o_busy && !flush && i_byte_de;
    assign end_frame   = o_busy && !flush && i_frame_end;
    assign close_frame = flush && fifo_empty && (state == W_IDLE);
    assign push_ok     = push && !fifo_full && (32'(word_idx) < SLOT_CAP);
    assign push_addr   = (ADDR_W'(wr_slot) << SLOT_SHIFT) + ADDR_W'(32'(word_idx) * 32'(ADDR_STEP));
    assign o_ddr3_cmd  = 3'd0;

    // The slot the reader holds is stepped over once.
    always_comb begin
        slot_cand = (wr_slot >= 3'(SLOT_COUNT - 1)) ? 3'd0 : wr_slot + 3'd1;
        slot_nxt  = slot_cand;
        if (i_rd_busy && slot_cand == i_rd_slot)
            slot_nxt = (slot_cand >= 3'(SLOT_COUNT - 1)) ? 3'd0 : slot_cand + 3'd1;
    end

    always_comb begin
        sr_nxt    = sr;
        lane_nxt  = lane_cnt;
        push      = 1'b0;
        push_data = sr;
        push_mask = '0;
        if (take_byte) begin
            sr_nxt   = (sr << 8) | DATA_W'(i_byte_data);
            lane_nxt = lane_cnt + CW'(1);
            if (lane_nxt == CW'(NB)) begin
                push      = 1'b1;
                push_data = sr_nxt;
                lane_nxt  = '0;
            end
        end
        // Partial word: left-justify and mask the unused low lanes.
        if (end_frame && lane_nxt != '0) begin
            push      = 1'b1;
            push_data = sr_nxt << (8 * (NB - int'(lane_nxt)));
            push_mask = ~({NB{1'b1}} << (NB - int'(lane_nxt)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_slot       <= 3'(SLOT_COUNT - 1);
            o_busy        <= 1'b0;
            flush         <= 1'b0;
            sr            <= '0;
            lane_cnt      <= '0;
            byte_cnt      <= '0;
            word_idx      <= '0;
            o_frame_done  <= 1'b0;
            o_frame_slot  <= '0;
            o_frame_bytes <= '0;
            o_overflow    <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            sr           <= sr_nxt;
            lane_cnt     <= lane_nxt;
            if (take_byte && byte_cnt != '1)
                byte_cnt <= byte_cnt + LEN_W'(1);
            if (push) begin
                word_idx <= word_idx + LEN_W'(1);
                if (!push_ok)
                    o_overflow <= 1'b1;
            end
            if (end_frame)
                flush <= 1'b1;
            if (open_frame) begin
                wr_slot  <= slot_nxt;
                byte_cnt <= '0;
                word_idx <= '0;
                lane_cnt <= '0;
                o_busy   <= 1'b1;
            end
            if (close_frame) begin
                o_frame_done  <= 1'b1;
                o_frame_slot  <= wr_slot;
                o_frame_bytes <= byte_cnt;
                o_busy        <= 1'b0;
                flush         <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= push_data;
            mem_mask[wr_ptr] <= push_mask;
            mem_addr[wr_ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            burst_cnt <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (state == W_IDLE)
                burst_cnt <= '0;
            else if (pop)
                burst_cnt <= burst_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= W_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            W_IDLE:
                if (level >= (AW+1)'(BURST_LEN) || (flush && !fifo_empty))
                    state_nxt = W_ISSUE;
            W_ISSUE:
                if (i_ddr3_cmd_ready && i_ddr3_wr_data_rdy) begin
                    pop       = 1'b1;
                    state_nxt = W_GAP;
                end
            W_GAP:
                state_nxt = (burst_cnt < BW'(BURST_LEN) && !fifo_empty) ? W_ISSUE : W_IDLE;
            default:
                state_nxt = W_IDLE;
        endcase
    end

    // Strobes last one cycle; data/addr/mask hold between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ddr3_cmd_en      <= 1'b0;
            o_ddr3_wr_data_en  <= 1'b0;
            o_ddr3_wr_data_end <= 1'b0;
            o_ddr3_wr_data     <= '0;
            o_ddr3_wr_mask     <= '0;
            o_ddr3_addr        <= '0;
        end else begin
            o_ddr3_cmd_en      <= pop;
            o_ddr3_wr_data_en  <= pop;
            o_ddr3_wr_data_end <= pop;
            if (pop) begin
                o_ddr3_wr_data <= mem_data[rd_ptr];
                o_ddr3_wr_mask <= mem_mask[rd_ptr];
                o_ddr3_addr    <= mem_addr[rd_ptr];
            end
        end
    end
endmodule

// File: doc/mjpeg_ddr3_wr_packer.md
# mjpeg_ddr3_wr_packer

Parametrised successor to the MJPEG-to-DDR3 write path. It packs the MJPEG encoder's byte stream into DATA_W-bit words and buffers them in a word FIFO. It writes the words to the DDR3 controller in bursts of up to BURST_LEN commands, rotating frames across SLOT_COUNT frame slots and skipping the slot the UDP reader holds. End-of-frame flush emits a byte-masked partial word and reports the slot and byte length to the UDP side.

## Interface
- DATA_W, 128: DDR3 word width; multiple of 8; NB = DATA_W/8 byte lanes.
- FIFO_DEPTH, 16: word FIFO depth; power of 2, ≥ BURST_LEN.
- BURST_LEN, 8: max words per uninterrupted write burst (1..FIFO_DEPTH).
- SLOT_COUNT, 4: frame slots (2..8).
- ADDR_W, 28: DDR3 address width.
- ADDR_STEP, 8: address increment per word.
- SLOT_SHIFT, 22: slot base = slot << SLOT_SHIFT; slot capacity = 2^SLOT_SHIFT / ADDR_STEP words.
- LEN_W, 24: byte-length counter width.
- clk  in  1  sole clock (camera pixel clock domain).
- rst  in  1  asynchronous, active-high reset.
- i_frame_start  in  1  one-cycle pulse; open a new frame.
- i_frame_end  in  1  one-cycle pulse; flush and close the current frame.
- i_byte_de  in  1  byte valid; no backpressure.
- i_byte_data  in  8  MJPEG byte.
- i_rd_busy  in  1  UDP reader holds slot i_rd_slot.
- i_rd_slot  in  3  slot held by reader.
- o_ddr3_cmd  out  3  always 3'd0 (write).
- o_ddr3_cmd_en  out  1  command strobe.
- o_ddr3_addr  out  ADDR_W  word address.
- i_ddr3_cmd_ready  in  1  controller accepts command.
- i_ddr3_wr_data_rdy  in  1  controller accepts data.
- o_ddr3_wr_data  out  DATA_W  write word.
- o_ddr3_wr_data_en  out  1  data strobe.
- o_ddr3_wr_data_end  out  1  equals o_ddr3_wr_data_en (one beat per command).
- o_ddr3_wr_mask  out  NB  bit i = 1 masks lane i (bits 8i+7:8i).
- o_busy  out  1  frame open or flush pending.
- o_frame_done  out  1  one-cycle pulse: frame fully written.
- o_frame_slot  out  3  slot of last completed frame.
- o_frame_bytes  out  LEN_W  byte length of last completed frame.
- o_overflow  out  1  sticky; a word was dropped.

## Operation
- All outputs reset to 0. Write-slot register resets to SLOT_COUNT-1, so the first frame uses slot 0.
- Frame open: on i_frame_start with o_busy=0, the slot advances to (slot+1) mod SLOT_COUNT. If i_rd_busy is set and the candidate equals i_rd_slot, it advances once more. The byte count and word index clear, and o_busy goes to 1.
- i_frame_start while o_busy=1 is ignored. Bytes arriving while o_busy=0 are discarded.
- Packing: the first byte of a word goes in lane NB-1, i.e. the word is shifted left and the new byte enters the LSBs. After NB bytes the word is pushed with mask 0. The byte counter saturates at 2^LEN_W-1.
- i_frame_end: a byte arriving in the same cycle is included first. If (bytes mod NB) = n ≠ 0, the partial word is pushed left-justified with zero-filled low lanes and mask = (1<<(NB-n))-1. Flush mode is then set.
- Push with FIFO full, or with word index ≥ slot capacity: the word is dropped, o_overflow is set, and the word index still advances.
- Each FIFO entry carries {data, mask, address}. Address = (slot<<SLOT_SHIFT) + word_index*ADDR_STEP, truncated to ADDR_W.
- Write FSM states:
  - W_IDLE → W_ISSUE when FIFO level ≥ BURST_LEN, or when flush is set and the FIFO is non-empty.
  - W_ISSUE: when i_ddr3_cmd_ready && i_ddr3_wr_data_rdy, pop one entry and drive cmd_en/wr_data_en/wr_data_end high for exactly one cycle with its data, address and mask. Then go to W_GAP.
  - W_GAP: strobes go low. Return to W_ISSUE if fewer than BURST_LEN words have gone out in this burst and the FIFO is non-empty; otherwise go to W_IDLE.
- Frame close: when flush is set, the FIFO is empty and the FSM is in W_IDLE, the block pulses o_frame_done, latches o_frame_slot/o_frame_bytes, and clears o_busy and flush.
- A zero-byte frame closes with no DDR3 writes and o_frame_bytes=0.

## Timing
- Full word is pushed to the FIFO on the clock after its NB-th byte is sampled.
- Word reaches DDR3 ports at the earliest 2 cycles after the push that meets the threshold: W_IDLE→W_ISSUE, then the strobe cycle.
- Throughput is one word per 2 clocks while both readies stay high. Ready low holds W_ISSUE with no loss.
- o_frame_done rises 2 cycles after the last word's strobe cycle, or 2 cycles after i_frame_end if the FIFO is already empty.
- o_ddr3_wr_data/addr/mask hold their last values when strobes are low.
- Reset mid-burst: all strobes drop immediately, the FIFO empties, and the frame is abandoned with no o_frame_done.

## Test plan
- Defaults, BURST_LEN=4, readies high: frame_start, bytes 0x00..0x3F, frame_end → 4 writes at addr 0,8,16,24, slot 0. Word0 = 0x000102…0F, mask 0x0000. o_frame_bytes=64, o_frame_slot=0.
- 20 bytes 0x00..0x13 then frame_end → 2 writes. Word1 = 0x10111213 followed by 12 zero bytes, mask 0x0FFF. o_frame_bytes=20.
- SLOT_COUNT=3, i_rd_busy=1, i_rd_slot=1, three 16-byte frames → slots 0, 2, 0 at bases 0x000000, 0x800000, 0x000000.
- i_ddr3_cmd_ready low for 50 cycles during a 128-byte frame → no strobes while low; all 8 words are then written in order, o_overflow=0.
- cmd_ready held low, (FIFO_DEPTH+1)×16 bytes, then release → o_overflow=1, exactly FIFO_DEPTH writes, o_frame_done still pulses with o_frame_bytes=272.
- rst asserted during a burst → strobes low the same cycle, no o_frame_done. The next frame starts at slot 0, addr 0.
